// File: rtl/cbd_pkg.sv
// cbd_pkg: shared constants, types and helpers for the CBD sampling path
package cbd_pkg;
  localparam int N = 256;
  localparam int WORD_BYTES = 8;
  typedef enum logic [1:0] {IDLE, FILL, FULL} collector_state_t;
  typedef logic [7:0] byte_t;
  function automatic int nbytes(input int eta);
    return 64 * eta;
  endfunction
endpackage

// File: rtl/cbd_prf_collector.sv
// cbd_prf_collector: unpacks SHAKE256 squeeze words little-endian into the CBD PRF byte buffer
module cbd_prf_collector
  import cbd_pkg::*;
#(
  parameter int ETA = 2,
  parameter int WORD_W = 64,
  localparam int NBYTES = nbytes(ETA)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [WORD_W-1:0] word_in,
  input  logic              word_valid,
  output logic              word_ready,
  output byte_t             byte_array [NBYTES],
  output logic [7:0]        len,
  output logic              buf_valid,
  input  logic              buf_ack,
  output logic              cbd_enable,
  output logic              busy
);
  localparam int NWORDS = NBYTES / WORD_BYTES;
  localparam int CW = $clog2(NWORDS) + 1;
  if (WORD_W != 64 || (ETA != 2 && ETA != 3)) begin : g_bad_param
    $error("cbd_prf_collector: ETA must be 2 or 3 and WORD_W must be 64");
  end
  collector_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic take;
  byte_t lane [WORD_BYTES];
  for (genvar k = 0; k < WORD_BYTES; k++) begin : g_lane
    assign lane[k] = word_in[8*k +: 8];
  end
  assign len = 8'(NBYTES);
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    word_ready = state == FILL;
    busy = state == FILL;
    buf_valid = state == FULL;
    cbd_enable = state == FULL;
    take = word_ready && word_valid && !start;
    if (state == IDLE && start) begin
      state_n = FILL;
      cnt_n = '0;
    end else if (state == FILL && start) begin
      cnt_n = '0;
    end else if (take) begin
      state_n = cnt == CW'(NWORDS - 1) ? FULL : FILL;
      cnt_n = cnt == CW'(NWORDS - 1) ? '0 : cnt + 1'b1;
    end else if (state == FULL && buf_ack) begin
      state_n = start ? FILL : IDLE;
      cnt_n = '0;
    end
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      for (int i = 0; i < NBYTES; i++) byte_array[i] <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      for (int w = 0; w < NWORDS; w++)
        for (int b = 0; b < WORD_BYTES; b++)
          if (take && cnt == CW'(w)) byte_array[w*WORD_BYTES+b] <= lane[b];
    end
  end
endmodule

// File: tb/tb_cbd_prf_collector.sv
// tb_cbd_prf_collector: directed table-driven check of the PRF byte collector
module tb_cbd_prf_collector;
  import cbd_pkg::*;
  typedef struct {
    logic s, v, a;
    logic [63:0] w;
    logic e_ready, e_valid, e_busy;
  } vec_t;
  logic clk = 0, reset = 0, start = 0, word_valid = 0, buf_ack = 0;
  logic [63:0] word_in = '0;
  logic word_ready, buf_valid, cbd_enable, busy;
  logic [7:0] len;
  byte_t ba [128];
  logic s3 = 0, v3 = 0;
  logic [63:0] w3 = '0;
  logic ready3, valid3, en3, busy3;
  logic [7:0] len3;
  byte_t ba3 [192];
  int n_cmp = 0, n_bad = 0;
  vec_t tv [18];
  always #5 clk = ~clk;
  cbd_prf_collector #(.ETA(2)) dut (
    .clk(clk), .reset(reset), .start(start), .word_in(word_in), .word_valid(word_valid),
    .word_ready(word_ready), .byte_array(ba), .len(len), .buf_valid(buf_valid),
    .buf_ack(buf_ack), .cbd_enable(cbd_enable), .busy(busy)
  );
  cbd_prf_collector #(.ETA(3)) dut3 (
    .clk(clk), .reset(reset), .start(s3), .word_in(w3), .word_valid(v3),
    .word_ready(ready3), .byte_array(ba3), .len(len3), .buf_valid(valid3),
    .buf_ack(1'b0), .cbd_enable(en3), .busy(busy3)
  );
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic drive(input logic s, input logic v, input logic a, input logic [63:0] w);
    start = s;
    word_valid = v;
    buf_ack = a;
    word_in = w;
  endtask
  function automatic int nz();
    int c = 0;
    for (int i = 0; i < 128; i++) if (ba[i] != 8'h00) c++;
    return c;
  endfunction
  initial begin
    int acc;
    cyc;
    cyc;
    chk("rst_valid", buf_valid, 0);
    chk("rst_ready", word_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_len", len, 128);
    chk("rst_bytes_nonzero", nz(), 0);
    reset = 1;
    tv[0] = '{1'b1, 1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 16; i++)
      tv[i+1] = '{1'b0, 1'b1, 1'b0, {8{i[7:0]}}, i < 15, i == 15, i < 15};
    tv[17] = '{1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b1, 1'b0};
    for (int i = 0; i < 18; i++) begin
      drive(tv[i].s, tv[i].v, tv[i].a, tv[i].w);
      cyc;
      chk($sformatf("tv%0d_ready", i), word_ready, tv[i].e_ready);
      chk($sformatf("tv%0d_valid", i), buf_valid, tv[i].e_valid);
      chk($sformatf("tv%0d_busy", i), busy, tv[i].e_busy);
      chk($sformatf("tv%0d_cbd_en", i), cbd_enable, tv[i].e_valid);
    end
    chk("fill_b0", ba[0], 8'h00);
    chk("fill_b7", ba[7], 8'h00);
    chk("fill_b64", ba[64], 8'h08);
    chk("fill_b120", ba[120], 8'h0F);
    chk("fill_b127", ba[127], 8'h0F);
    chk("fill_len", len, 128);
    drive(0, 1, 0, '1);
    cyc;
    cyc;
    chk("full_hold_b8", ba[8], 8'h01);
    chk("full_hold_b127", ba[127], 8'h0F);
    chk("full_hold_ready", word_ready, 0);
    drive(0, 0, 1, 0);
    cyc;
    chk("ack_valid", buf_valid, 0);
    chk("ack_busy", busy, 0);
    drive(1, 0, 0, 0);
    cyc;
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, i == 0 ? 64'h0706050403020100 : 64'h0);
      cyc;
    end
    chk("le_valid", buf_valid, 1);
    chk("le_b0", ba[0], 8'h00);
    chk("le_b3", ba[3], 8'h03);
    chk("le_b7", ba[7], 8'h07);
    chk("le_b8", ba[8], 8'h00);
    drive(0, 0, 1, 0);
    cyc;
    drive(1, 0, 0, 0);
    cyc;
    acc = 0;
    for (int c = 0; c < 32; c++) begin
      drive(0, c % 2 == 0, 0, {8{8'(32 + acc)}});
      cyc;
      if (c % 2 == 0) acc++;
      chk($sformatf("bp%0d_valid", c), buf_valid, acc == 16);
    end
    chk("bp_b0", ba[0], 8'h20);
    chk("bp_b40", ba[40], 8'h25);
    chk("bp_b127", ba[127], 8'h2F);
    drive(0, 0, 1, 0);
    cyc;
    drive(1, 0, 0, 0);
    cyc;
    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, {8{8'hAA}});
      cyc;
    end
    drive(1, 1, 0, {8{8'hEE}});
    cyc;
    chk("rs_busy", busy, 1);
    for (int i = 0; i < 16; i++) begin
      drive(0, 1, 0, {8{8'(64 + i)}});
      cyc;
      chk($sformatf("rs%0d_valid", i), buf_valid, i == 15);
    end
    chk("rs_b0", ba[0], 8'h40);
    chk("rs_b39", ba[39], 8'h44);
    chk("rs_b40", ba[40], 8'h45);
    chk("rs_b127", ba[127], 8'h4F);
    drive(1, 0, 0, 0);
    cyc;
    chk("start_noack_valid", buf_valid, 1);
    drive(1, 0, 1, 0);
    cyc;
    chk("start_ack_valid", buf_valid, 0);
    chk("start_ack_busy", busy, 1);
    chk("start_ack_ready", word_ready, 1);
    for (int i = 0; i < 9; i++) begin
      drive(0, 1, 0, {8{8'h5A}});
      cyc;
    end
    drive(0, 0, 0, 0);
    reset = 0;
    cyc;
    reset = 1;
    chk("mid_rst_valid", buf_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ready", word_ready, 0);
    chk("mid_rst_nonzero", nz(), 0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, i == 1, '1);
      cyc;
      chk($sformatf("idle%0d_ready", i), word_ready, 0);
      chk($sformatf("idle%0d_valid", i), buf_valid, 0);
    end
    chk("idle_nonzero", nz(), 0);
    drive(0, 0, 0, 0);
    s3 = 1;
    cyc;
    s3 = 0;
    for (int i = 0; i < 24; i++) begin
      v3 = 1;
      w3 = {8{8'(96 + i)}};
      cyc;
      chk($sformatf("e3_%0d_valid", i), valid3, i == 23);
    end
    v3 = 0;
    chk("e3_len", len3, 192);
    chk("e3_b128", ba3[128], 8'h70);
    chk("e3_b191", ba3[191], 8'h77);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/cbd_prf_collector.md
Name: cbd_prf_collector

Overview:
- Producer side of the CBD sampling interface: it assembles the PRF byte string that the CBD sampler consumes.
- Accepts 64-bit squeeze words from the SHAKE256 PRF over a valid/ready handshake and unpacks them little-endian into a 64*ETA-byte buffer.
- Presents the full buffer, stable, with a valid/ack handshake and a CBD enable.
- Sits between the Keccak squeeze output and the CBD wrapper.

Parameters:
- ETA, 2, CBD eta. Legal values are 2 and 3. The buffer holds NBYTES = 64*ETA bytes.
- WORD_W, 64, squeeze word width in bits. Fixed at 64 (one Keccak lane).

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- start  input  1  single-cycle pulse; begins a new fill.
- word_in  input  64  PRF squeeze word; byte k = word_in[8k+7:8k].
- word_valid  input  1  word_in is valid this cycle.
- word_ready  output  1  collector accepts word_in this cycle.
- byte_array  output  8 x NBYTES  assembled PRF bytes, index 0 first.
- len  output  8  constant NBYTES (128 for ETA=2, 192 for ETA=3).
- buf_valid  output  1  byte_array complete and stable.
- buf_ack  input  1  consumer has latched byte_array.
- cbd_enable  output  1  equals buf_valid; drives the CBD enable.
- busy  output  1  high in the FILL state.

Behaviour:
- Reset (reset==0 at a clock edge):
  - state goes to IDLE, word counter to 0, every byte_array entry to 8'h00.
  - buf_valid, cbd_enable, word_ready and busy go to 0.
  - Reset takes priority over every other input, including mid-fill and in FULL; a partial fill is discarded.
- Word counter: width $clog2(NWORDS)+1, where NWORDS = NBYTES/8 (16 for ETA=2, 24 for ETA=3).
- State IDLE:
  - word_ready=0.
  - start -> FILL; counter cleared.
  - Words presented in IDLE are not accepted.
- State FILL:
  - word_ready=1 and busy=1.
  - On word_valid && word_ready: byte_array[8*cnt+k] <= word_in[8k+7:8k] for k=0..7, then cnt <= cnt+1.
  - When the accepted word is number NWORDS-1: next state FULL, counter cleared.
  - buf_valid rises in the cycle after the last accepted word (latency 1).
  - start during FILL restarts the fill: counter <= 0 and any word presented in that cycle is dropped. start has priority over the word transfer. Previously written bytes remain until overwritten.
- State FULL:
  - word_ready=0; buf_valid=1; cbd_enable=1.
  - byte_array is held unchanged until the ack.
  - buf_ack -> IDLE; buf_valid drops the next cycle.
  - start without buf_ack is ignored.
  - start and buf_ack in the same cycle -> FILL directly; counter cleared, buf_valid 0 the next cycle.
- buf_ack outside FULL is ignored.
- Throughput: one word per cycle while word_valid is held. A full ETA=2 fill takes 16 accepted cycles.
- Backpressure: word_valid may drop between words. The counter advances only on accepted transfers.
- len is a combinational constant; it does not depend on reset.
- Illegal ETA is rejected at elaboration by an assertion.

Decomposition:
- Shared package cbd_pkg:
  - localparam N=256.
  - function nbytes(eta) = 64*eta.
  - localparam WORD_BYTES=8.
  - typedef enum logic [1:0] {IDLE, FILL, FULL} collector_state_t.
  - typedef logic [7:0] byte_t.
- Single module, no sub-module. The byte-lane unpack is a generate loop inside the module.

Test Plan:
- ETA=2. Reset, start, then 16 consecutive words where word i = {8{8'(i)}}:
  - word_ready is 1 for exactly those 16 cycles.
  - buf_valid is 1 in the cycle after the 16th word.
  - byte_array[0..7]=8'h00, byte_array[120..127]=8'h0F, len=128.
- Word 0 = 64'h0706050403020100, words 1..15 = 0:
  - byte_array[0]=8'h00, byte_array[3]=8'h03, byte_array[7]=8'h07, byte_array[8]=8'h00.
- Backpressure. word_valid toggles 1,0,1,0 across 32 cycles:
  - counter advances only on valid cycles; buf_valid after the 16th accepted word.
  - In FULL, a held word_valid=1 with word_in=64'hFFFF... leaves byte_array unchanged.
- start pulse after 5 accepted words, then 16 further words:
  - buf_valid only after the 16th post-restart word; byte_array reflects only the post-restart words.
- In FULL, assert start and buf_ack together:
  - next cycle buf_valid=0, busy=1, word_ready=1.
  - start alone in FULL (no ack): buf_valid stays 1.
- reset=0 for one cycle after 9 words:
  - state IDLE, buf_valid=0, all bytes 8'h00.
  - Words with no new start are ignored (word_ready=0).
- ETA=3 build: fill completes after 24 words; len=192.
